// File: rtl/scan_display.sv
// scan_display: 4-digit common-anode 7-segment scanner with a per-frame digit snapshot.
// Optional macro LEADING_ZERO_BLANK_EN darkens leading zero minute / tens-of-seconds digits.
module scan_display #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned DIV_BITS = 16,
    parameter logic [3:0]  DP_MASK  = 4'b1010
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic [3:0] q_0,
    input  logic [3:0] q_s_0,
    input  logic [3:0] q_s_1,
    input  logic [3:0] q_m,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam logic [DIV_BITS-1:0] PRESC_LAST = DIV_BITS'(SCAN_DIV - 1);

    logic [DIV_BITS-1:0] presc_q, presc_d;
    logic [1:0]          idx_q, idx_d;
    logic [15:0]         snap_q, snap_d;
    logic [3:0]          an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic                tick;
    logic                blank;
    logic [3:0]          digit;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + DIV_BITS'(1);
        idx_d   = tick ? idx_q + 2'd1 : idx_q;
        // All four digits are captured together on the frame wrap so the display never tears.
        snap_d  = (tick && idx_q == 2'd3) ? {q_m, q_s_1, q_s_0, q_0} : snap_q;

        case (idx_q)
            2'd0:    digit = snap_q[3:0];
            2'd1:    digit = snap_q[7:4];
            2'd2:    digit = snap_q[11:8];
            default: digit = snap_q[15:12];
        endcase

        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx_q == 2'd3 && snap_q[15:12] == 4'd0)
            blank = 1'b1;
        if (idx_q == 2'd2 && snap_q[15:12] == 4'd0 && snap_q[11:8] == 4'd0)
            blank = 1'b1;
`endif

        seg_d = bcd_to_seg(digit);
        if (!en || blank) begin
            an_d = 4'b1111;
            dp_d = 1'b1;
        end else begin
            an_d = ~(4'b0001 << idx_q);
            dp_d = ~DP_MASK[idx_q];
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
            snap_q  <= 16'h0000;
            an_q    <= 4'b1111;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_scan_display.sv
// Scoreboard bench for scan_display with SCAN_DIV=4: stimulus queues per-slot expectations,
// a negedge monitor pops and compares them in the middle of each scan slot.
module tb_scan_display;

    localparam logic [3:0] DPM = 4'b1010;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       en  = 1'b1;
    logic [3:0] q_0 = 4'd0, q_s_0 = 4'd0, q_s_1 = 4'd0, q_m = 4'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_cmp = 0;
    int n_bad = 0;
    int edges = 0;

    typedef struct {
        int         slot;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        bit         chk_seg;
    } exp_t;

    exp_t sbq[$];

    scan_display #(.SCAN_DIV(4), .DIV_BITS(3), .DP_MASK(DPM)) dut (
        .clk(clk), .clr(clr), .en(en),
        .q_0(q_0), .q_s_0(q_s_0), .q_s_1(q_s_1), .q_m(q_m),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge clr) begin
        if (clr) edges <= 0;
        else     edges <= edges + 1;
    end

    task automatic check(input string name, input logic [11:0] act,
                         input logic [11:0] req, input logic [11:0] mask);
        n_cmp++;
        if (((act ^ req) & mask) !== 12'd0) begin
            n_bad++;
            $display("FAIL %s: got an/seg/dp=%b_%b_%b want %b_%b_%b (mask %b)",
                     name, act[11:8], act[7:1], act[0], req[11:8], req[7:1], req[0], mask);
        end
    endtask

    function automatic logic [6:0] segof(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic push_frame(input int base, input int d3, input int d2,
                              input int d1, input int d0, input bit en_on);
        int   d[4];
        exp_t e;
        bit   dark;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        for (int i = 0; i < 4; i++) begin
            dark = !en_on;
`ifdef LEADING_ZERO_BLANK_EN
            if (i == 3 && d3 == 0) dark = 1'b1;
            if (i == 2 && d3 == 0 && d2 == 0) dark = 1'b1;
`endif
            e.slot    = base + i;
            e.seg     = segof(d[i]);
            e.chk_seg = !dark;
            e.an      = dark ? 4'b1111 : ~(4'b0001 << i);
            e.dp      = dark ? 1'b1 : ~DPM[i];
            sbq.push_back(e);
        end
    endtask

    task automatic wait_edges(input int n);
        while (edges < n) @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        int   slot;
        exp_t e;
        if (!clr && edges >= 2 && ((edges - 2) % 4) == 0) begin
            slot = (edges - 2) / 4;
            while (sbq.size() > 0 && sbq[0].slot < slot) begin
                n_cmp++;
                n_bad++;
                $display("FAIL slot_missed: expected slot %0d never sampled (now slot %0d)",
                         sbq[0].slot, slot);
                void'(sbq.pop_front());
            end
            if (sbq.size() > 0 && sbq[0].slot == slot) begin
                e = sbq.pop_front();
                check($sformatf("slot%0d", slot), {an, seg, dp}, {e.an, e.seg, e.dp},
                      {4'hF, e.chk_seg ? 7'h7F : 7'h00, 1'b1});
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        // Asynchronous reset asserted between clock edges.
        #22 clr = 1'b1;
        #1 check("reset_async", {an, seg, dp}, {4'b1111, 7'h7F, 1'b1}, 12'hFFF);
        @(negedge clk);
        clr = 1'b0;
        q_m = 4'd3; q_s_1 = 4'd5; q_s_0 = 4'd9; q_0 = 4'd7;
        push_frame(0, 0, 0, 0, 0, 1'b1);
        push_frame(4, 3, 5, 9, 7, 1'b1);

        wait_edges(4);
        check("first_idx_hold", {an, 8'h00}, {4'b1110, 8'h00}, 12'hF00);
        wait_edges(5);
        check("first_idx_step", {an, 8'h00}, {4'b1101, 8'h00}, 12'hF00);

        // Mid-frame input change must wait for the next frame wrap.
        wait_edges(21);
        q_0 = 4'd2; q_s_1 = 4'd8;
        push_frame(8, 3, 8, 9, 2, 1'b1);

        wait_edges(33);
        q_s_0 = 4'hC;
        push_frame(12, 3, 8, 12, 2, 1'b1);

        wait_edges(64);
        en = 1'b0;
        push_frame(16, 3, 8, 12, 2, 1'b0);
        wait_edges(80);
        en = 1'b1;
        push_frame(20, 3, 8, 12, 2, 1'b1);

        wait_edges(84);
        q_m = 4'd0; q_s_1 = 4'd0; q_s_0 = 4'd4; q_0 = 4'd2;
        push_frame(24, 0, 0, 4, 2, 1'b1);

        // Reset pulse while idx=2 in the following frame.
        wait_edges(122);
        clr = 1'b1;
        #1 check("reset_midframe", {an, seg, dp}, {4'b1111, 7'h7F, 1'b1}, 12'hFFF);
        @(negedge clk);
        clr = 1'b0;
        push_frame(0, 0, 0, 0, 0, 1'b1);
        push_frame(4, 0, 0, 4, 2, 1'b1);

        wait_edges(31);
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
